spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI master. It accepts one word per start/ready handshake, asserts the selected chip select, and drives `spi_clk_gen` through `cg_go`/`cg_last_clk`. It counts SCLK edges from that block's `cg_pos_edge`/`cg_neg_edge` flags, shifts MOSI and samples MISO per CPOL/CPHA, and returns the received word with a one-cycle `done` pulse.

---
 rtl/spi_xfer_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master transfer sequencer; frames one word per start/ready handshake and drives spi_clk_gen.
// Build option: define SPI_XFER_LSB_FIRST_EN to add the i_lsb_first input (LSB-first shifting).
module spi_xfer_ctrl #(
    parameter int  C_DIVIDER_WIDTH = 8,
    parameter int  C_DATA_WIDTH    = 8,
    parameter int  C_NUM_CS        = 4,
    localparam int C_CS_W          = (C_NUM_CS > 1) ? $clog2(C_NUM_CS) : 1
) (
    input  logic                       sysclk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic                       i_start,
    output logic                       o_ready,
    input  logic [C_DATA_WIDTH-1:0]    i_tx_data,
    input  logic [C_CS_W-1:0]          i_cs_sel,
    input  logic                       i_cpol,
    input  logic                       i_cpha,
`ifdef SPI_XFER_LSB_FIRST_EN
    input  logic                       i_lsb_first,
`endif
    input  logic [C_DIVIDER_WIDTH-1:0] i_divider,
    output logic [C_DATA_WIDTH-1:0]    o_rx_data,
    output logic                       o_done,
    output logic                       o_busy,
    output logic [C_NUM_CS-1:0]        o_spi_cs_n,
    output logic                       o_mosi,
    input  logic                       i_miso,
    output logic                       o_cg_go,
    output logic                       o_cg_last_clk,
    output logic                       o_cg_cpol,
    output logic [C_DIVIDER_WIDTH-1:0] o_cg_divider,
    input  logic                       i_cg_pos_edge,
    input  logic                       i_cg_neg_edge,
    output logic [2:0]                 o_dbg_state
);

    localparam int C_EDGE_W = $clog2(2 * C_DATA_WIDTH + 1);
    localparam logic [C_EDGE_W-1:0] C_LAST_EDGE = C_EDGE_W'(2 * C_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [C_DIVIDER_WIDTH-1:0]  r_cnt;
    logic [C_DIVIDER_WIDTH-1:0]  r_div_q;
    logic [C_CS_W-1:0]           r_cs_q;
    logic                        r_cpol_q;
    logic                        r_cpha_q;
    logic                        r_lsb_q;
    logic [C_DATA_WIDTH-1:0]     r_sh;
    logic [C_DATA_WIDTH-1:0]     r_rx;
    logic [C_DATA_WIDTH-1:0]     r_rx_data;
    logic [C_EDGE_W-1:0]         r_edge_cnt;
    logic                        r_mosi;
    logic                        r_done;

    logic                        w_lsb_in;
    logic                        w_accept;
    logic                        w_cnt_end;
    logic                        w_lead;
    logic                        w_trail;
    logic                        w_is_lead;
    logic                        w_edge;
    logic                        w_sample;
    logic                        w_shift;
    logic                        w_cs_active;
    logic [C_NUM_CS-1:0]         w_cs_n;
    logic                        w_tx_first;
    logic [C_DATA_WIDTH-1:0]     w_tx_rest;
    logic                        w_sh_bit;
    logic [C_DATA_WIDTH-1:0]     w_sh_next;
    logic [C_DATA_WIDTH-1:0]     w_rx_next;

`ifdef SPI_XFER_LSB_FIRST_EN
    assign w_lsb_in = i_lsb_first;
`else
    assign w_lsb_in = 1'b0;
`endif

    assign o_ready   = (r_state == S_IDLE) && i_enable;
    assign w_accept  = i_start && o_ready;
    assign w_cnt_end = (r_cnt == r_div_q);

    // Only the edge expected next is counted, so coincident flags at divider 0 cannot double-count.
    assign w_lead    = r_cpol_q ? i_cg_neg_edge : i_cg_pos_edge;
    assign w_trail   = r_cpol_q ? i_cg_pos_edge : i_cg_neg_edge;
    assign w_is_lead = ~r_edge_cnt[0];
    assign w_edge    = (r_state == S_XFER) && (w_is_lead ? w_lead : w_trail);
    assign w_sample  = w_edge && (w_is_lead != r_cpha_q);
    assign w_shift   = w_edge && (w_is_lead == r_cpha_q) && (r_edge_cnt != C_LAST_EDGE);

    assign w_tx_first = w_lsb_in ? i_tx_data[0] : i_tx_data[C_DATA_WIDTH-1];
    assign w_tx_rest  = w_lsb_in ? (i_tx_data >> 1) : (i_tx_data << 1);
    assign w_sh_bit   = r_lsb_q ? r_sh[0] : r_sh[C_DATA_WIDTH-1];
    assign w_sh_next  = r_lsb_q ? (r_sh >> 1) : (r_sh << 1);
    assign w_rx_next  = r_lsb_q ? {i_miso, r_rx[C_DATA_WIDTH-1:1]}
                                : {r_rx[C_DATA_WIDTH-2:0], i_miso};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: if (w_cnt_end) w_next = S_XFER;
            S_XFER:  if (w_edge && (r_edge_cnt == C_LAST_EDGE)) w_next = S_HOLD;
            S_HOLD:  if (w_cnt_end) w_next = S_GAP;
            S_GAP:   if (w_cnt_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (!i_enable) w_next = S_IDLE;
    end

    assign w_cs_active = (r_state == S_SETUP) || (r_state == S_XFER) || (r_state == S_HOLD);

    always_comb begin
        w_cs_n = '1;
        for (int i = 0; i < C_NUM_CS; i++) begin
            if (w_cs_active && (r_cs_q == C_CS_W'(i))) w_cs_n[i] = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div_q    <= '0;
            r_cs_q     <= '0;
            r_cpol_q   <= 1'b0;
            r_cpha_q   <= 1'b0;
            r_lsb_q    <= 1'b0;
            r_sh       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_edge_cnt <= '0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state != S_IDLE) && (r_state != S_XFER)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_div_q    <= i_divider;
                r_cs_q     <= i_cs_sel;
                r_cpol_q   <= i_cpol;
                r_cpha_q   <= i_cpha;
                r_lsb_q    <= w_lsb_in;
                r_edge_cnt <= '0;
                r_rx       <= '0;
                // CPHA=0 presents the first bit during SETUP; CPHA=1 waits for the first leading edge.
                r_mosi     <= i_cpha ? 1'b0 : w_tx_first;
                r_sh       <= i_cpha ? i_tx_data : w_tx_rest;
            end
            if (w_edge) r_edge_cnt <= r_edge_cnt + 1'b1;
            if (w_sample) r_rx <= w_rx_next;
            if (w_shift) begin
                r_mosi <= w_sh_bit;
                r_sh   <= w_sh_next;
            end
            if ((r_state == S_HOLD) && (w_next == S_GAP)) begin
                r_rx_data <= r_rx;
                r_done    <= 1'b1;
            end
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_rx_data     = r_rx_data;
    assign o_spi_cs_n    = w_cs_n;
    assign o_mosi        = r_mosi;
    assign o_cg_go       = (r_state == S_XFER);
    assign o_cg_last_clk = (r_state == S_XFER) && (r_edge_cnt >= C_LAST_EDGE);
    assign o_cg_cpol     = r_cpol_q;
    assign o_cg_divider  = r_div_q;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: self-checking bench for spi_xfer_ctrl with a clock-generator model,
// an SPI slave model and per-transfer expectations derived from the transfer rules.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;

    localparam int DW   = 8;
    localparam int DIVW = 8;
    localparam int NCS  = 4;

    logic            sysclk    = 1'b0;
    logic            rst_n     = 1'b0;
    logic            enable    = 1'b0;
    logic            start     = 1'b0;
    logic            cpol      = 1'b0;
    logic            cpha      = 1'b0;
    logic            lsb_first = 1'b0;
    logic [DW-1:0]   tx_data   = '0;
    logic [1:0]      cs_sel    = '0;
    logic [DIVW-1:0] divider   = '0;

    logic            ready, done, busy, mosi, miso;
    logic            cg_go, cg_last_clk, cg_cpol;
    logic [DW-1:0]   rx_data;
    logic [NCS-1:0]  spi_cs_n;
    logic [DIVW-1:0] cg_divider;
    logic [2:0]      dbg_state;

    logic            tb_sclk, tb_pos, tb_neg;
    logic [DIVW-1:0] tb_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic            cur_cpol    = 1'b0;
    logic            cur_cpha    = 1'b0;
    logic            loop_en     = 1'b0;
    logic            m_clr       = 1'b1;
    logic [DW-1:0]   s_word      = '0;
    logic [NCS-1:0]  exp_cs_mask = '1;
    logic [DW-1:0]   last_exp_rx = '0;

    int m_pos = 0, m_edges = 0, m_setup = 0, m_hold = 0, m_last = 0;
    int m_done = 0, m_cs_bad = 0, m_rdy_bad = 0, s_shifts = 0, s_idx;
    logic          m_seen_go = 1'b0;
    logic [DW-1:0] s_cap = '0;
    logic          w_lead_f, w_trail_f;

    always #5 sysclk = ~sysclk;

    spi_xfer_ctrl #(.C_DIVIDER_WIDTH(DIVW), .C_DATA_WIDTH(DW), .C_NUM_CS(NCS)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .i_enable(enable), .i_start(start), .o_ready(ready),
        .i_tx_data(tx_data), .i_cs_sel(cs_sel), .i_cpol(cpol), .i_cpha(cpha),
`ifdef SPI_XFER_LSB_FIRST_EN
        .i_lsb_first(lsb_first),
`endif
        .i_divider(divider), .o_rx_data(rx_data), .o_done(done), .o_busy(busy),
        .o_spi_cs_n(spi_cs_n), .o_mosi(mosi), .i_miso(miso), .o_cg_go(cg_go),
        .o_cg_last_clk(cg_last_clk), .o_cg_cpol(cg_cpol), .o_cg_divider(cg_divider),
        .i_cg_pos_edge(tb_pos), .i_cg_neg_edge(tb_neg), .o_dbg_state(dbg_state)
    );

    // Clock generator model: toggles SCLK every divider+1 cycles while go is high and
    // stops once SCLK is back at idle with last_clk asserted.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tb_sclk <= 1'b0; tb_cnt <= '0; tb_pos <= 1'b0; tb_neg <= 1'b0;
        end else if (!cg_go) begin
            tb_sclk <= cg_cpol; tb_cnt <= '0; tb_pos <= 1'b0; tb_neg <= 1'b0;
        end else if (cg_last_clk && (tb_sclk == cg_cpol)) begin
            tb_pos <= 1'b0; tb_neg <= 1'b0;
        end else if (tb_cnt == cg_divider) begin
            tb_cnt <= '0; tb_sclk <= ~tb_sclk; tb_pos <= ~tb_sclk; tb_neg <= tb_sclk;
        end else begin
            tb_cnt <= tb_cnt + 1'b1; tb_pos <= 1'b0; tb_neg <= 1'b0;
        end
    end

    assign w_lead_f  = cur_cpol ? tb_neg : tb_pos;
    assign w_trail_f = cur_cpol ? tb_pos : tb_neg;

    // Slave model: MSB-first word out on its shift edges, MOSI captured on its sample edges.
    always_comb begin
        s_idx = cur_cpha ? (s_shifts - 1) : s_shifts;
        if (loop_en) miso = mosi;
        else if ((s_idx >= 0) && (s_idx < DW)) miso = s_word[DW-1-s_idx];
        else miso = 1'b0;
    end

    always @(posedge sysclk) begin
        if (m_clr) begin
            m_pos <= 0; m_edges <= 0; m_setup <= 0; m_hold <= 0; m_last <= 0;
            m_done <= 0; m_cs_bad <= 0; m_rdy_bad <= 0; s_shifts <= 0;
            m_seen_go <= 1'b0; s_cap <= '0;
        end else begin
            if (tb_pos) m_pos <= m_pos + 1;
            if (tb_pos || tb_neg) m_edges <= m_edges + 1;
            if (spi_cs_n != '1) begin
                if (spi_cs_n != exp_cs_mask) m_cs_bad <= m_cs_bad + 1;
                if (ready) m_rdy_bad <= m_rdy_bad + 1;
                if (cg_go) m_seen_go <= 1'b1;
                else if (m_seen_go) m_hold <= m_hold + 1;
                else m_setup <= m_setup + 1;
            end
            if (cg_last_clk) m_last <= m_last + 1;
            if (done) m_done <= m_done + 1;
            if (cur_cpha ? w_lead_f : w_trail_f) s_shifts <= s_shifts + 1;
            if (cur_cpha ? w_trail_f : w_lead_f) s_cap <= {s_cap[DW-2:0], mosi};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic logic [DW-1:0] rev_bits(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
        return r;
    endfunction

    task automatic begin_xfer(input logic p_cpol, input logic p_cpha, input logic p_lsb,
                              input logic p_loop, input logic [DIVW-1:0] p_div,
                              input logic [DW-1:0] p_tx, input logic [DW-1:0] p_slave,
                              input logic [1:0] p_cs, input string tag);
        @(negedge sysclk);
        cur_cpol = p_cpol; cur_cpha = p_cpha; loop_en = p_loop; s_word = p_slave;
        exp_cs_mask = ~(NCS'(1) << p_cs);
        cpol = p_cpol; cpha = p_cpha; lsb_first = p_lsb; divider = p_div;
        tx_data = p_tx; cs_sel = p_cs; start = 1'b1; m_clr = 1'b1;
        chk({tag, " ready"}, 32'(ready), 32'd1);
        @(negedge sysclk);
        start = 1'b0; m_clr = 1'b0;
        // Change every latched input: the transfer in flight must not notice.
        tx_data = ~p_tx; cs_sel = p_cs + 2'd1; cpol = ~p_cpol; cpha = ~p_cpha;
        divider = p_div + 8'd3; lsb_first = ~p_lsb;
        chk({tag, " cs low"}, 32'(spi_cs_n), 32'(exp_cs_mask));
        if (!p_cpha) chk({tag, " first mosi"}, 32'(mosi), 32'(p_lsb ? p_tx[0] : p_tx[DW-1]));
    endtask

    task automatic run_xfer(input logic p_cpol, input logic p_cpha, input logic p_lsb,
                            input logic p_loop, input logic [DIVW-1:0] p_div,
                            input logic [DW-1:0] p_tx, input logic [DW-1:0] p_slave,
                            input logic [1:0] p_cs, input string tag);
        int k;
        logic [DW-1:0] exp_rx;
        exp_rx = p_loop ? p_tx : p_slave;
        begin_xfer(p_cpol, p_cpha, p_lsb, p_loop, p_div, p_tx, p_slave, p_cs, tag);
        k = 0;
        while ((done !== 1'b1) && (k < 4000)) begin @(negedge sysclk); k++; end
        chk({tag, " done seen"}, 32'(done), 32'd1);
        chk({tag, " rx_data"}, 32'(rx_data), 32'(exp_rx));
        last_exp_rx = exp_rx;
        k = 0;
        while ((ready !== 1'b1) && (k < 64)) begin @(negedge sysclk); k++; end
        chk({tag, " done to ready"}, 32'(k), 32'(p_div) + 32'd1);
        chk({tag, " rising sclk"}, 32'(m_pos), 32'(DW));
        chk({tag, " sclk edges"}, 32'(m_edges), 32'(2 * DW));
        chk({tag, " setup len"}, 32'(m_setup), 32'(p_div) + 32'd1);
        chk({tag, " hold len"}, 32'(m_hold), 32'(p_div) + 32'd1);
        chk({tag, " last_clk len"}, 32'(m_last), 32'(p_div) + 32'd1);
        chk({tag, " cs select"}, 32'(m_cs_bad), 32'd0);
        chk({tag, " ready in xfer"}, 32'(m_rdy_bad), 32'd0);
        chk({tag, " done pulses"}, 32'(m_done), 32'd1);
        chk({tag, " slave got"}, 32'(s_cap), 32'(p_lsb ? rev_bits(p_tx) : p_tx));
    endtask

    initial begin
        int k;
        repeat (3) @(negedge sysclk);
        chk("rst cs_n", 32'(spi_cs_n), 32'hF);
        chk("rst mosi", 32'(mosi), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst rx_data", 32'(rx_data), 32'd0);
        chk("rst cg_go", 32'(cg_go), 32'd0);
        chk("rst cg_last_clk", 32'(cg_last_clk), 32'd0);
        chk("rst cg_cpol", 32'(cg_cpol), 32'd0);
        chk("rst cg_divider", 32'(cg_divider), 32'd0);
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge sysclk);
        enable = 1'b1;
        #1;
        chk("ready follows enable", 32'(ready), 32'd1);

        run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'hA5, 8'h00, 2'd2, "mode0 loop");
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h3C, 8'hC3, 2'd1, "mode3 div0");
        run_xfer(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h96, 8'h5E, 2'd0, "mode1 div3");
        run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'h0F, 8'hB2, 2'd3, "mode2 div3");

        begin_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'h5A, 8'h96, 2'd2, "abort");
        k = 0;
        while ((m_edges < 5) && (k < 500)) begin @(negedge sysclk); k++; end
        chk("abort edges reached", 32'(m_edges), 32'd5);
        enable = 1'b0;
        @(negedge sysclk);
        chk("abort cs_n", 32'(spi_cs_n), 32'hF);
        chk("abort cg_go", 32'(cg_go), 32'd0);
        chk("abort cg_last_clk", 32'(cg_last_clk), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        repeat (10) @(negedge sysclk);
        chk("abort no done", 32'(m_done), 32'd0);
        chk("abort rx kept", 32'(rx_data), 32'(last_exp_rx));
        enable = 1'b1;
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'hE1, 8'h4D, 2'd1, "after abort");

        // start held high across three transfers
        @(negedge sysclk);
        cur_cpol = 1'b0; cur_cpha = 1'b0; loop_en = 1'b1; exp_cs_mask = 4'b1101;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; divider = 8'd2; tx_data = 8'h69;
        cs_sel = 2'd1; start = 1'b1; m_clr = 1'b1;
        @(negedge sysclk);
        m_clr = 1'b0;
        for (int t = 0; t < 3; t++) begin
            k = 0;
            while ((done !== 1'b1) && (k < 2000)) begin @(negedge sysclk); k++; end
            chk("b2b done seen", 32'(done), 32'd1);
            chk("b2b rx_data", 32'(rx_data), 32'h69);
            if (t < 2) begin
                k = 0;
                while ((spi_cs_n == '1) && (k < 64)) begin @(negedge sysclk); k++; end
                chk("b2b cs high gap", 32'(k), 32'd4);
            end
            if (t == 1) start = 1'b0;
        end
        k = 0;
        while ((ready !== 1'b1) && (k < 64)) begin @(negedge sysclk); k++; end
        chk("b2b ready in xfer", 32'(m_rdy_bad), 32'd0);
        chk("b2b done count", 32'(m_done), 32'd3);
        chk("b2b cs select", 32'(m_cs_bad), 32'd0);

`ifdef SPI_XFER_LSB_FIRST_EN
        run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 8'h01, 8'h00, 2'd0, "lsb first");
`endif

        for (int r = 0; r < 8; r++) begin
            run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     2'($urandom_range(0, 3)), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
